mem_access_unit: RTL and testbench

- Memory (ME) stage of the 5-stage RV32I pipeline, directly downstream of the EX/ME pipeline register.
- Consumes the registered ME-stage signals and runs loads and stores on a req/gnt/rvalid data bus.
- Generates byte enables, then aligns and sign- or zero-extends load data.
- Stalls the upstream pipeline until the access completes, detects misaligned accesses, and times out hung bus transactions.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus interface between the ME-stage memory access unit (master) and the
// data memory or interconnect (slave), using a req/gnt/rvalid handshake.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: issues loads/stores on the data bus, aligns and extends
// load data, stalls upstream while busy, and flags misalignment and bus timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              ALU_result_M,
    input  logic [31:0]              write_data_M,
    input  logic [1:0]               wb_ctrl_M,
    input  logic                     we_mem_M,
    input  logic [2:0]               ls_type_M,
    input  logic [31:0]              PC_M,
    mem_access_unit_if.master        dbus,
    output logic [31:0]              load_data_M,
    output logic                     stall_M,
    output logic                     misalign_exc,
    output logic                     bus_err,
    output logic [31:0]              exc_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ls_type_q;
    logic [1:0]       offset_q;

    logic        access;
    logic        misaligned;
    logic        start;
    logic        timeout_hit;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [31:0] rdata_shift;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign access       = we_mem_M | (wb_ctrl_M == 2'b01);
    assign misalign_exc = (state == IDLE) & access & misaligned;
    assign start        = (state == IDLE) & access & ~misaligned;
    // Reset gates the stall so the pipeline is released even while a held
    // instruction still presents an access.
    assign stall_M      = rst_n & (start | (state == REQ) | (state == WAIT));
    assign timeout_hit  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        misaligned = 1'b0;
        case (ls_type_M)
            3'b001, 3'b101: misaligned = ALU_result_M[0];
            3'b010:         misaligned = |ALU_result_M[1:0];
            default:        misaligned = 1'b0;
        endcase
    end

    // Store lane steering; loads always read the full word.
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = write_data_M;
        if (we_mem_M) begin
            case (ls_type_M[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << ALU_result_M[1:0];
                    wdata_nxt = {4{write_data_M[7:0]}};
                end
                2'b01: begin
                    be_nxt    = ALU_result_M[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{write_data_M[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = write_data_M;
                end
            endcase
        end
    end

    assign rdata_shift = dbus.rdata >> {offset_q, 3'b000};
    assign half_sel    = offset_q[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];

    always_comb begin
        load_ext = dbus.rdata;
        case (ls_type_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'b0, rdata_shift[7:0]};
            3'b101:  load_ext = {16'b0, half_sel};
            default: load_ext = dbus.rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ls_type_q   <= '0;
            offset_q    <= '0;
            dbus.req    <= 1'b0;
            dbus.we     <= 1'b0;
            dbus.addr   <= '0;
            dbus.wdata  <= '0;
            dbus.be     <= '0;
            load_data_M <= '0;
            bus_err     <= 1'b0;
            exc_pc      <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignments so every
            // branch sees the pre-edge values regardless of statement order.
            bus_err <= 1'b0;
            if (misalign_exc) exc_pc <= PC_M;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state      <= REQ;
                        dbus.req   <= 1'b1;
                        dbus.we    <= we_mem_M;
                        dbus.addr  <= {ALU_result_M[31:2], 2'b00};
                        dbus.wdata <= wdata_nxt;
                        dbus.be    <= be_nxt;
                        ls_type_q  <= ls_type_M;
                        offset_q   <= ALU_result_M[1:0];
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dbus.gnt) begin
                        dbus.req <= 1'b0;
                        state    <= dbus.we ? DONE : WAIT;
                    end else if (timeout_hit) begin
                        dbus.req    <= 1'b0;
                        bus_err     <= 1'b1;
                        exc_pc      <= PC_M;
                        load_data_M <= '0;
                        state       <= DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dbus.rvalid) begin
                        load_data_M <= load_ext;
                        state       <= DONE;
                    end else if (timeout_hit) begin
                        bus_err     <= 1'b1;
                        exc_pc      <= PC_M;
                        load_data_M <= '0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalignment, timeout,
// mid-transaction reset and back-to-back accesses against hand-computed values.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALU_result_M;
    logic [31:0] write_data_M;
    logic [1:0]  wb_ctrl_M;
    logic        we_mem_M;
    logic [2:0]  ls_type_M;
    logic [31:0] PC_M;
    logic [31:0] load_data_M;
    logic        stall_M;
    logic        misalign_exc;
    logic        bus_err;
    logic [31:0] exc_pc;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit_if dbus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES (255),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ALU_result_M (ALU_result_M),
        .write_data_M (write_data_M),
        .wb_ctrl_M    (wb_ctrl_M),
        .we_mem_M     (we_mem_M),
        .ls_type_M    (ls_type_M),
        .PC_M         (PC_M),
        .dbus         (dbus),
        .load_data_M  (load_data_M),
        .stall_M      (stall_M),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err),
        .exc_pc       (exc_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1-2 time units after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] wb,
                         input logic we, input logic [2:0] ls, input logic [31:0] pc);
        ALU_result_M = addr;
        write_data_M = wd;
        wb_ctrl_M    = wb;
        we_mem_M     = we;
        ls_type_M    = ls;
        PC_M         = pc;
        #1;
    endtask

    task automatic no_op;
        wb_ctrl_M = 2'b00;
        we_mem_M  = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int err_pulses;
        int req_low;
        int req_high;

        rst_n        = 1'b1;
        ALU_result_M = '0;
        write_data_M = '0;
        wb_ctrl_M    = 2'b00;
        we_mem_M     = 1'b0;
        ls_type_M    = 3'b000;
        PC_M         = '0;
        dbus.gnt     = 1'b0;
        dbus.rvalid  = 1'b0;
        dbus.rdata   = '0;
        #2 rst_n = 1'b0;
        tick;
        tick;

        check("rst_req",    dbus.req,    0);
        check("rst_we",     dbus.we,     0);
        check("rst_addr",   dbus.addr,   0);
        check("rst_wdata",  dbus.wdata,  0);
        check("rst_be",     dbus.be,     0);
        check("rst_stall",  stall_M,     0);
        check("rst_buserr", bus_err,     0);
        check("rst_load",   load_data_M, 0);
        check("rst_excpc",  exc_pc,      0);
        rst_n = 1'b1;
        tick;

        // SB at byte 3: lane 3 enabled, byte replicated to all lanes.
        issue(32'h1003, 32'h0000_00AB, 2'b00, 1'b1, 3'b000, 32'h100);
        check("sb_idle_stall", stall_M, 1);
        check("sb_idle_req",   dbus.req, 0);
        tick;
        check("sb_req",   dbus.req,   1);
        check("sb_be",    dbus.be,    4'b1000);
        check("sb_wdata", dbus.wdata, 32'hABAB_ABAB);
        check("sb_addr",  dbus.addr,  32'h1000);
        check("sb_we",    dbus.we,    1);
        check("sb_stall", stall_M,    1);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        check("sb_done_stall", stall_M,  0);
        check("sb_done_req",   dbus.req, 0);
        no_op;
        tick;
        check("sb_idle_after", stall_M, 0);

        // SH to upper halfword.
        issue(32'h1006, 32'h0000_BEEF, 2'b00, 1'b1, 3'b001, 32'h104);
        tick;
        check("sh_be",    dbus.be,    4'b1100);
        check("sh_wdata", dbus.wdata, 32'hBEEF_BEEF);
        check("sh_addr",  dbus.addr,  32'h1004);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        no_op;
        tick;

        // LH at offset 2, rvalid one cycle after gnt.
        issue(32'h2002, 32'h0, 2'b01, 1'b0, 3'b001, 32'h200);
        check("lh_idle_stall", stall_M, 1);
        tick;
        check("lh_req",   dbus.req,  1);
        check("lh_be",    dbus.be,   4'b1111);
        check("lh_we",    dbus.we,   0);
        check("lh_addr",  dbus.addr, 32'h2000);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        check("lh_wait_req",   dbus.req, 0);
        check("lh_wait_stall", stall_M,  1);
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h8001_1234;
        tick;
        dbus.rvalid = 1'b0;
        check("lh_data",       load_data_M, 32'hFFFF_8001);
        check("lh_done_stall", stall_M,     0);
        no_op;
        tick;

        // LHU on the same data; an rvalid during REQ must be ignored.
        issue(32'h2002, 32'h0, 2'b01, 1'b0, 3'b101, 32'h204);
        tick;
        dbus.rvalid = 1'b1;
        tick;
        dbus.rvalid = 1'b0;
        check("lhu_rvalid_in_req_req",  dbus.req,    1);
        check("lhu_rvalid_in_req_data", load_data_M, 32'hFFFF_8001);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b1;
        tick;
        dbus.rvalid = 1'b0;
        check("lhu_data", load_data_M, 32'h0000_8001);
        no_op;
        tick;

        // Misaligned LW: exception only, no bus activity, no stall.
        issue(32'h3001, 32'h0, 2'b01, 1'b0, 3'b010, 32'h300);
        check("mis_exc",   misalign_exc, 1);
        check("mis_stall", stall_M,      0);
        check("mis_req",   dbus.req,     0);
        tick;
        check("mis_excpc",   exc_pc,   32'h300);
        check("mis_req_nxt", dbus.req, 0);
        no_op;
        check("mis_exc_clear", misalign_exc, 0);
        tick;

        // Load that is never granted: timeout at the 255th REQ cycle.
        issue(32'h5000, 32'h0, 2'b01, 1'b0, 3'b010, 32'h500);
        tick;
        err_pulses = 0;
        req_low    = 0;
        for (int i = 1; i <= 255; i++) begin
            if (bus_err)   err_pulses++;
            if (!dbus.req) req_low++;
            if (i < 255) tick;
        end
        check("to_no_early_err", err_pulses, 0);
        check("to_req_held",     req_low,    0);
        check("to_stall_held",   stall_M,    1);
        tick;
        check("to_buserr", bus_err,     1);
        check("to_load0",  load_data_M, 0);
        check("to_excpc",  exc_pc,      32'h500);
        check("to_stall",  stall_M,     0);
        check("to_req",    dbus.req,    0);
        no_op;
        tick;
        check("to_buserr_pulse", bus_err, 0);
        err_pulses = 0;
        req_high   = 0;
        for (int i = 0; i < 44; i++) begin
            tick;
            if (bus_err)  err_pulses++;
            if (dbus.req) req_high++;
        end
        check("to_no_repeat_err", err_pulses, 0);
        check("to_no_reissue",    req_high,   0);

        // Reset while waiting for read data aborts the load.
        issue(32'h6000, 32'h0, 2'b01, 1'b0, 3'b000, 32'h600);
        tick;
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        check("rw_wait_stall", stall_M, 1);
        rst_n = 1'b0;
        #1;
        check("rw_req",    dbus.req, 0);
        check("rw_stall",  stall_M,  0);
        check("rw_excpc",  exc_pc,   0);
        tick;
        check("rw_stall_held", stall_M, 0);
        rst_n = 1'b1;
        no_op;
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h0000_00FF;
        tick;
        dbus.rvalid = 1'b0;
        check("rw_no_completion", load_data_M, 0);
        check("rw_idle_stall",    stall_M,     0);

        issue(32'h4000, 32'h1234_5678, 2'b00, 1'b1, 3'b010, 32'h400);
        check("sw_idle_stall", stall_M, 1);
        tick;
        check("sw_be",    dbus.be,    4'b1111);
        check("sw_wdata", dbus.wdata, 32'h1234_5678);
        check("sw_addr",  dbus.addr,  32'h4000);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        check("sw_done_stall", stall_M, 0);
        no_op;
        tick;

        // Back-to-back LB then SW with an IDLE cycle in between.
        issue(32'h10, 32'h0, 2'b01, 1'b0, 3'b000, 32'h10);
        tick;
        check("b2b_lb_req", dbus.req, 1);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt    = 1'b0;
        dbus.rvalid = 1'b1;
        dbus.rdata  = 32'h0000_00F0;
        tick;
        dbus.rvalid = 1'b0;
        check("b2b_lb_data", load_data_M, 32'hFFFF_FFF0);
        check("b2b_done_req", dbus.req, 0);
        tick;
        issue(32'h20, 32'hCAFE_F00D, 2'b00, 1'b1, 3'b010, 32'h14);
        check("b2b_idle_req",   dbus.req, 0);
        check("b2b_idle_stall", stall_M,  1);
        tick;
        check("b2b_sw_req",   dbus.req,   1);
        check("b2b_sw_addr",  dbus.addr,  32'h20);
        check("b2b_sw_wdata", dbus.wdata, 32'hCAFE_F00D);
        dbus.gnt = 1'b1;
        tick;
        dbus.gnt = 1'b0;
        no_op;
        tick;
        check("b2b_post1_req", dbus.req, 0);
        tick;
        check("b2b_post2_req", dbus.req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
